// File: rtl/cache_system.sv
// cache_system: 4-way set-associative, one-word-line cache with true-LRU
// replacement and a built-in backing RAM (ram_inst.mem).
// WRITE_BACK = 0 selects write-through, 1 selects write-back; both write-allocate.
// Optional build macro CACHE_PERF_CNT_EN adds saturating hitCount/missCount outputs.

module cache_ram #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Synchronous write, synchronous read with one cycle of latency; never reset
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

module cache_system #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_WAYS    = 4,
    parameter int NUM_SETS    = 64,
    parameter int OFFSET_W    = 0,
    parameter int SET_INDEX_W = 6,
    parameter int TAG_WIDTH   = 10,
    parameter int WRITE_BACK  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpuRead,
    input  logic                  cpuWrite,
    input  logic [ADDR_WIDTH-1:0] cpuAddr,
    input  logic [DATA_WIDTH-1:0] cpuWriteData,
    output logic [DATA_WIDTH-1:0] cpuReadData,
    output logic                  done,
    output logic                  ready
`ifdef CACHE_PERF_CNT_EN
   ,output logic [31:0]           hitCount,
    output logic [31:0]           missCount
`endif
);
    localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int AGE_W = WAY_W;
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(NUM_WAYS - 1);
    localparam bit WB = (WRITE_BACK != 0);

    typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, MEM_RD, FILL, DONE} state_t;
    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic                   is_wr_q;
    logic [WAY_W-1:0]       vic_q;

    logic                   valid_q [NUM_SETS][NUM_WAYS];
    logic                   dirty_q [NUM_SETS][NUM_WAYS];
    logic [AGE_W-1:0]       age_q   [NUM_SETS][NUM_WAYS];
    logic [TAG_WIDTH-1:0]   tag_q   [NUM_SETS][NUM_WAYS];
    logic [DATA_WIDTH-1:0]  data_q  [NUM_SETS][NUM_WAYS];

    logic [SET_INDEX_W-1:0] set_idx;
    logic [TAG_WIDTH-1:0]   addr_tag;
    logic                   hit, vic_inv_found, vic_dirty;
    logic [WAY_W-1:0]       hit_way, victim;
    logic [AGE_W-1:0]       max_age;

    logic                   line_we, line_dirty, lru_en;
    logic [WAY_W-1:0]       line_way, lru_way;
    logic [DATA_WIDTH-1:0]  line_data;
    logic [AGE_W-1:0]       lru_age;

    logic                   ram_we, ram_re;
    logic [ADDR_WIDTH-1:0]  ram_waddr;
    logic [DATA_WIDTH-1:0]  ram_wdata, ram_rdata;

    assign set_idx  = addr_q[SET_INDEX_W+OFFSET_W-1:OFFSET_W];
    assign addr_tag = addr_q[ADDR_WIDTH-1:ADDR_WIDTH-TAG_WIDTH];
    assign done     = (state_q == DONE);
    assign ready    = (state_q == IDLE) && !rst;
    assign ram_re   = (state_q == MEM_RD);

    cache_ram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) ram_inst (
        .clk(clk), .we(ram_we), .waddr(ram_waddr), .wdata(ram_wdata),
        .re(ram_re), .raddr(addr_q), .rdata(ram_rdata)
    );

    // Tag match and victim choice: lowest invalid way, else the oldest way
    always_comb begin
        hit = 1'b0;
        hit_way = '0;
        vic_inv_found = 1'b0;
        victim = '0;
        max_age = '0;
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            if (!hit && valid_q[set_idx][w] && tag_q[set_idx][w] == addr_tag) begin
                hit = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            if (!vic_inv_found && !valid_q[set_idx][w]) begin
                vic_inv_found = 1'b1;
                victim = WAY_W'(w);
            end
        end
        if (!vic_inv_found) begin
            for (int unsigned w = 0; w < NUM_WAYS; w++) begin
                if (age_q[set_idx][w] > max_age) begin
                    max_age = age_q[set_idx][w];
                    victim = WAY_W'(w);
                end
            end
        end
        vic_dirty = WB && valid_q[set_idx][victim] && dirty_q[set_idx][victim];
    end

    // Next-state selection
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (cpuRead || cpuWrite) state_d = LOOKUP;
            LOOKUP: begin
                if (hit)            state_d = DONE;
                else if (vic_dirty) state_d = WRITEBACK;
                else if (is_wr_q)   state_d = DONE;
                else                state_d = MEM_RD;
            end
            WRITEBACK: state_d = is_wr_q ? DONE : MEM_RD;
            MEM_RD:    state_d = FILL;
            FILL:      state_d = DONE;
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Line write, LRU touch and RAM write strobes for the current state
    always_comb begin
        line_we    = 1'b0;
        line_way   = hit_way;
        line_data  = wdata_q;
        line_dirty = 1'b0;
        lru_en     = 1'b0;
        lru_way    = hit_way;
        lru_age    = age_q[set_idx][hit_way];
        ram_we     = 1'b0;
        ram_waddr  = addr_q;
        ram_wdata  = wdata_q;
        unique case (state_q)
            LOOKUP: begin
                if (hit) begin
                    lru_en = 1'b1;
                    if (is_wr_q) begin
                        line_we    = 1'b1;
                        line_dirty = WB;
                        ram_we     = !WB;
                    end
                end else if (is_wr_q && !vic_dirty) begin
                    line_we    = 1'b1;
                    line_way   = victim;
                    line_dirty = WB;
                    ram_we     = !WB;
                    lru_en     = 1'b1;
                    lru_way    = victim;
                    lru_age    = AGE_MAX;
                end
            end
            WRITEBACK: begin
                ram_we    = 1'b1;
                ram_waddr = {tag_q[set_idx][vic_q], set_idx};
                ram_wdata = data_q[set_idx][vic_q];
                // Write miss: the new word is installed as the old one leaves
                if (is_wr_q) begin
                    line_we    = 1'b1;
                    line_way   = vic_q;
                    line_dirty = WB;
                    lru_en     = 1'b1;
                    lru_way    = vic_q;
                    lru_age    = AGE_MAX;
                end
            end
            FILL: begin
                line_we   = 1'b1;
                line_way  = vic_q;
                line_data = ram_rdata;
                lru_en    = 1'b1;
                lru_way   = vic_q;
                lru_age   = AGE_MAX;
            end
            default: ;
        endcase
    end

    // Resettable control state: FSM, read data, valid/dirty/LRU
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cpuReadData <= '0;
            for (int unsigned s = 0; s < NUM_SETS; s++) begin
                for (int unsigned w = 0; w < NUM_WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    age_q[s][w]   <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            if (state_q == LOOKUP && hit && !is_wr_q) cpuReadData <= data_q[set_idx][hit_way];
            if (state_q == FILL) cpuReadData <= ram_rdata;
            if (line_we) begin
                valid_q[set_idx][line_way] <= 1'b1;
                dirty_q[set_idx][line_way] <= line_dirty;
            end
            if (lru_en) begin
                for (int unsigned w = 0; w < NUM_WAYS; w++) begin
                    if (WAY_W'(w) == lru_way)
                        age_q[set_idx][w] <= '0;
                    else if (valid_q[set_idx][w] && age_q[set_idx][w] < lru_age)
                        age_q[set_idx][w] <= age_q[set_idx][w] + AGE_W'(1);
                end
            end
        end
    end

    // Non-reset datapath: request latch, victim, tag and data arrays
    always_ff @(posedge clk) begin
        if (state_q == IDLE && (cpuRead || cpuWrite)) begin
            addr_q  <= cpuAddr;
            wdata_q <= cpuWriteData;
            is_wr_q <= !cpuRead;
        end
        if (state_q == LOOKUP) vic_q <= victim;
        if (line_we) begin
            tag_q[set_idx][line_way]  <= addr_tag;
            data_q[set_idx][line_way] <= line_data;
        end
    end

`ifdef CACHE_PERF_CNT_EN
    // Saturating hit/miss counters, one step per lookup outcome
    always_ff @(posedge clk) begin
        if (rst) begin
            hitCount  <= '0;
            missCount <= '0;
        end else if (state_q == LOOKUP) begin
            if (hit) begin
                if (hitCount != '1) hitCount <= hitCount + 32'd1;
            end else if (missCount != '1) begin
                missCount <= missCount + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_cache_system.sv
// Directed testbench for cache_system: one write-through and one write-back instance.
module tb_cache_system;
    logic        clk = 1'b0;
    logic        rst;
    logic        rd    [2];
    logic        wr    [2];
    logic [15:0] addr  [2];
    logic [31:0] wdat  [2];
    logic [31:0] rdat  [2];
    logic        done_s  [2];
    logic        ready_s [2];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cache_system #(.WRITE_BACK(0)) dut_wt (
        .clk(clk), .rst(rst), .cpuRead(rd[0]), .cpuWrite(wr[0]), .cpuAddr(addr[0]),
        .cpuWriteData(wdat[0]), .cpuReadData(rdat[0]), .done(done_s[0]), .ready(ready_s[0])
    );
    cache_system #(.WRITE_BACK(1)) dut_wb (
        .clk(clk), .rst(rst), .cpuRead(rd[1]), .cpuWrite(wr[1]), .cpuAddr(addr[1]),
        .cpuWriteData(wdat[1]), .cpuReadData(rdat[1]), .done(done_s[1]), .ready(ready_s[1])
    );

    task automatic mem_wr(input int sel, input logic [15:0] a, input logic [31:0] d);
        if (sel == 0) dut_wt.ram_inst.mem[a] = d;
        else          dut_wb.ram_inst.mem[a] = d;
    endtask

    function automatic logic [31:0] mem_rd(input int sel, input logic [15:0] a);
        if (sel == 0) return dut_wt.ram_inst.mem[a];
        return dut_wb.ram_inst.mem[a];
    endfunction

    // One request; cyc counts edges from the accept edge to the one raising done (-1 on timeout)
    task automatic do_access(input int sel, input bit r, input bit w, input logic [15:0] a,
                             input logic [31:0] d, output logic [31:0] data, output int cyc);
        @(posedge clk);
        @(negedge clk);
        checks++; if (ready_s[sel] !== 1'b1) begin failures++; $display("FAIL ready_idle: got %b want 1", ready_s[sel]); end
        rd[sel] = r; wr[sel] = w; addr[sel] = a; wdat[sel] = d;
        @(posedge clk); #1;
        rd[sel] = 1'b0; wr[sel] = 1'b0;
        cyc = 1;
        while (done_s[sel] !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (done_s[sel] !== 1'b1) cyc = -1;
        checks++; if (ready_s[sel] !== 1'b0) begin failures++; $display("FAIL done_ready_excl: ready %b want 0", ready_s[sel]); end
        data = rdat[sel];
    endtask

    task automatic test_reset;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin rd[i] = 0; wr[i] = 0; addr[i] = '0; wdat[i] = '0; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (ready_s[0] !== 1'b0) begin failures++; $display("FAIL rst_ready_wt: got %b want 0", ready_s[0]); end
        checks++; if (ready_s[1] !== 1'b0) begin failures++; $display("FAIL rst_ready_wb: got %b want 0", ready_s[1]); end
        checks++; if (done_s[0] !== 1'b0) begin failures++; $display("FAIL rst_done: got %b want 0", done_s[0]); end
        checks++; if (rdat[0] !== 32'h0) begin failures++; $display("FAIL rst_rdata: got %h want 0", rdat[0]); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (ready_s[0] !== 1'b1) begin failures++; $display("FAIL post_rst_ready: got %b want 1", ready_s[0]); end
        checks++; if (done_s[1] !== 1'b0) begin failures++; $display("FAIL post_rst_done: got %b want 0", done_s[1]); end
    endtask

    task automatic test_read_miss_hit;
        logic [31:0] v; int c;
        mem_wr(0, 16'h0010, 32'hDEADBEEF);
        do_access(0, 1, 0, 16'h0010, 0, v, c);
        checks++; if (v !== 32'hDEADBEEF) begin failures++; $display("FAIL miss_data: got %h want DEADBEEF", v); end
        checks++; if (c !== 4) begin failures++; $display("FAIL miss_lat: got %0d want 4", c); end
        do_access(0, 1, 0, 16'h0010, 0, v, c);
        checks++; if (v !== 32'hDEADBEEF) begin failures++; $display("FAIL hit_data: got %h want DEADBEEF", v); end
        checks++; if (c !== 2) begin failures++; $display("FAIL hit_lat: got %0d want 2", c); end
    endtask

    task automatic test_write_through;
        logic [31:0] v; int c;
        do_access(0, 0, 1, 16'h0010, 32'hCAFEBABE, v, c);
        checks++; if (mem_rd(0, 16'h0010) !== 32'hCAFEBABE) begin failures++; $display("FAIL wt_hit_ram: got %h want CAFEBABE", mem_rd(0, 16'h0010)); end
        checks++; if (c !== 2) begin failures++; $display("FAIL wt_hit_lat: got %0d want 2", c); end
        checks++; if (v !== 32'hDEADBEEF) begin failures++; $display("FAIL wt_rdata_hold: got %h want DEADBEEF", v); end
        do_access(0, 1, 0, 16'h0010, 0, v, c);
        checks++; if (v !== 32'hCAFEBABE) begin failures++; $display("FAIL wt_readback: got %h want CAFEBABE", v); end
        do_access(0, 0, 1, 16'h0020, 32'hAAAA5555, v, c);
        checks++; if (mem_rd(0, 16'h0020) !== 32'hAAAA5555) begin failures++; $display("FAIL wt_miss_ram: got %h want AAAA5555", mem_rd(0, 16'h0020)); end
        checks++; if (c !== 2) begin failures++; $display("FAIL wt_miss_lat: got %0d want 2", c); end
        do_access(0, 1, 0, 16'h0020, 0, v, c);
        checks++; if (v !== 32'hAAAA5555) begin failures++; $display("FAIL wt_miss_read: got %h want AAAA5555", v); end
        checks++; if (c !== 2) begin failures++; $display("FAIL wt_miss_read_lat: got %0d want 2", c); end
    endtask

    task automatic test_lru;
        logic [31:0] v; int c;
        logic [15:0] a [4] = '{16'h0003, 16'h0043, 16'h0083, 16'h00C3};
        logic [31:0] d [4] = '{32'hA0A0A0A0, 32'hB0B0B0B0, 32'hC0C0C0C0, 32'hD0D0D0D0};
        for (int i = 0; i < 4; i++) mem_wr(0, a[i], d[i]);
        mem_wr(0, 16'h0103, 32'hE0E0E0E0);
        for (int i = 0; i < 4; i++) begin
            do_access(0, 1, 0, a[i], 0, v, c);
            checks++; if (v !== d[i] || c !== 4) begin failures++; $display("FAIL lru_fill%0d: got %h/%0d want %h/4", i, v, c, d[i]); end
        end
        for (int i = 0; i < 4; i++) begin
            do_access(0, 1, 0, a[i], 0, v, c);
            checks++; if (v !== d[i] || c !== 2) begin failures++; $display("FAIL lru_hit%0d: got %h/%0d want %h/2", i, v, c, d[i]); end
        end
        do_access(0, 1, 0, 16'h0103, 0, v, c);
        checks++; if (v !== 32'hE0E0E0E0 || c !== 4) begin failures++; $display("FAIL lru_evict: got %h/%0d want E0E0E0E0/4", v, c); end
        do_access(0, 1, 0, 16'h0003, 0, v, c);
        checks++; if (v !== 32'hA0A0A0A0 || c !== 4) begin failures++; $display("FAIL lru_victim_gone: got %h/%0d want A0A0A0A0/4", v, c); end
        do_access(0, 1, 0, 16'h0083, 0, v, c);
        checks++; if (v !== 32'hC0C0C0C0 || c !== 2) begin failures++; $display("FAIL lru_survivor: got %h/%0d want C0C0C0C0/2", v, c); end
    endtask

    task automatic test_extremes;
        logic [31:0] v; int c;
        mem_wr(0, 16'hFFFF, 32'hFFFFFFFF);
        do_access(0, 1, 0, 16'hFFFF, 0, v, c);
        checks++; if (v !== 32'hFFFFFFFF || c !== 4) begin failures++; $display("FAIL addr_ffff: got %h/%0d want FFFFFFFF/4", v, c); end
        do_access(0, 0, 1, 16'h0100, 32'h99998888, v, c);
        do_access(0, 1, 0, 16'h0000, 0, v, c);
        checks++; if (v !== 32'h0 || c !== 4) begin failures++; $display("FAIL addr_0000: got %h/%0d want 0/4", v, c); end
        do_access(0, 1, 0, 16'h0100, 0, v, c);
        checks++; if (v !== 32'h99998888 || c !== 2) begin failures++; $display("FAIL addr_0100: got %h/%0d want 99998888/2", v, c); end
    endtask

    task automatic test_read_wins;
        logic [31:0] v; int c;
        do_access(0, 1, 1, 16'h0010, 32'h11111111, v, c);
        checks++; if (v !== 32'hCAFEBABE || c !== 2) begin failures++; $display("FAIL rw_read: got %h/%0d want CAFEBABE/2", v, c); end
        checks++; if (mem_rd(0, 16'h0010) !== 32'hCAFEBABE) begin failures++; $display("FAIL rw_ram: got %h want CAFEBABE", mem_rd(0, 16'h0010)); end
        do_access(0, 1, 0, 16'h0010, 0, v, c);
        checks++; if (v !== 32'hCAFEBABE) begin failures++; $display("FAIL rw_cache: got %h want CAFEBABE", v); end
    endtask

    task automatic test_write_back;
        logic [31:0] v; int c;
        logic [15:0] a [3] = '{16'h0045, 16'h0085, 16'h00C5};
        mem_wr(1, 16'h0005, 32'hC1EA0000);
        do_access(1, 1, 0, 16'h0005, 0, v, c);
        checks++; if (v !== 32'hC1EA0000 || c !== 4) begin failures++; $display("FAIL wb_read: got %h/%0d want C1EA0000/4", v, c); end
        do_access(1, 0, 1, 16'h0005, 32'hD1570000, v, c);
        checks++; if (c !== 2) begin failures++; $display("FAIL wb_hit_lat: got %0d want 2", c); end
        checks++; if (mem_rd(1, 16'h0005) !== 32'hC1EA0000) begin failures++; $display("FAIL wb_ram_untouched: got %h want C1EA0000", mem_rd(1, 16'h0005)); end
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 3; i++) begin
                do_access(1, 1, 0, a[i], 0, v, c);
                checks++; if (v !== 32'h0 || c !== (r == 0 ? 4 : 2)) begin failures++; $display("FAIL wb_fill_r%0d_%0d: got %h/%0d want 0/%0d", r, i, v, c, (r == 0 ? 4 : 2)); end
            end
        end
        do_access(1, 1, 0, 16'h0105, 0, v, c);
        checks++; if (c !== 5) begin failures++; $display("FAIL wb_evict_lat: got %0d want 5", c); end
        checks++; if (mem_rd(1, 16'h0005) !== 32'hD1570000) begin failures++; $display("FAIL wb_evict_ram: got %h want D1570000", mem_rd(1, 16'h0005)); end
        do_access(1, 1, 0, 16'h0005, 0, v, c);
        checks++; if (v !== 32'hD1570000 || c !== 4) begin failures++; $display("FAIL wb_reread: got %h/%0d want D1570000/4", v, c); end
        do_access(1, 0, 1, 16'h0200, 32'hA110CA7E, v, c);
        checks++; if (mem_rd(1, 16'h0200) !== 32'h0 || c !== 2) begin failures++; $display("FAIL wb_wmiss: got %h/%0d want 0/2", mem_rd(1, 16'h0200), c); end
        do_access(1, 0, 1, 16'h0240, 32'h00000240, v, c);
        do_access(1, 0, 1, 16'h0280, 32'h00000280, v, c);
        do_access(1, 0, 1, 16'h02C0, 32'h000002C0, v, c);
        do_access(1, 0, 1, 16'h0300, 32'h0BADF00D, v, c);
        checks++; if (c !== 3) begin failures++; $display("FAIL wb_wmiss_dirty_lat: got %0d want 3", c); end
        checks++; if (mem_rd(1, 16'h0200) !== 32'hA110CA7E) begin failures++; $display("FAIL wb_wmiss_evict: got %h want A110CA7E", mem_rd(1, 16'h0200)); end
        checks++; if (mem_rd(1, 16'h0300) !== 32'h0) begin failures++; $display("FAIL wb_wmiss_noram: got %h want 0", mem_rd(1, 16'h0300)); end
        do_access(1, 1, 0, 16'h0300, 0, v, c);
        checks++; if (v !== 32'h0BADF00D || c !== 2) begin failures++; $display("FAIL wb_wmiss_read: got %h/%0d want 0BADF00D/2", v, c); end
    endtask

    task automatic test_reset_abort;
        logic [31:0] v; int c;
        mem_wr(0, 16'h0777, 32'h12345678);
        @(negedge clk);
        rd[0] = 1'b1; addr[0] = 16'h0777;
        @(posedge clk); #1;
        rd[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (done_s[0] !== 1'b0 || ready_s[0] !== 1'b0) begin failures++; $display("FAIL abort_outputs: done %b ready %b want 0 0", done_s[0], ready_s[0]); end
        checks++; if (rdat[0] !== 32'h0) begin failures++; $display("FAIL abort_rdata: got %h want 0", rdat[0]); end
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (mem_rd(0, 16'h0777) !== 32'h12345678) begin failures++; $display("FAIL abort_ram: got %h want 12345678", mem_rd(0, 16'h0777)); end
        do_access(0, 1, 0, 16'h0777, 0, v, c);
        checks++; if (v !== 32'h12345678 || c !== 4) begin failures++; $display("FAIL abort_reread: got %h/%0d want 12345678/4", v, c); end
        do_access(0, 1, 0, 16'h0010, 0, v, c);
        checks++; if (v !== 32'hCAFEBABE || c !== 4) begin failures++; $display("FAIL abort_cleared: got %h/%0d want CAFEBABE/4", v, c); end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            dut_wt.ram_inst.mem[i] = '0;
            dut_wb.ram_inst.mem[i] = '0;
        end
        test_reset;
        test_read_miss_hit;
        test_write_through;
        test_lru;
        test_extremes;
        test_read_wins;
        test_write_back;
        test_reset_abort;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
